// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS-style execute stage: ALU, EX/MEM register, iterative MULTU (and DIVU with EXEC_DIV_EN)
// Optional divider: define EXEC_DIV_EN to enable the DIV state and restoring divider.
module execute_stage #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5,
    parameter int SHW     = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               alu_src,
    input  logic               reg_dst,
    input  logic               branch,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               reg_write,
    input  logic               mem_to_reg,
    input  logic [3:0]         alu_ctrl,
    input  logic [XLEN-1:0]    npc,
    input  logic [XLEN-1:0]    rs_data,
    input  logic [XLEN-1:0]    rt_data,
    input  logic [XLEN-1:0]    imm,
    input  logic [REGADDR-1:0] rt_addr,
    input  logic [REGADDR-1:0] rd_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_branch,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               out_reg_write,
    output logic               out_mem_to_reg,
    output logic               out_zero,
    output logic [XLEN-1:0]    out_target,
    output logic [XLEN-1:0]    out_alu,
    output logic [XLEN-1:0]    out_store,
    output logic [REGADDR-1:0] out_dest,
    output logic [XLEN-1:0]    hi,
    output logic [XLEN-1:0]    lo
);
    localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]  acc_q, acc_d, acc_step;
    logic [XLEN-1:0]    opb_q, opb_d;
    logic [3:0]         hold_ctl_q, hold_ctl_d;
    logic [XLEN-1:0]    hold_target_q, hold_target_d, hold_store_q, hold_store_d;
    logic [REGADDR-1:0] hold_dest_q, hold_dest_d;

    logic               out_valid_q, out_valid_d, out_rw_q, out_rw_d, out_zero_q, out_zero_d;
    logic [3:0]         out_ctl_q, out_ctl_d;
    logic [XLEN-1:0]    out_target_q, out_target_d, out_alu_q, out_alu_d, out_store_q, out_store_d;
    logic [REGADDR-1:0] out_dest_q, out_dest_d;
    logic [XLEN-1:0]    hi_q, hi_d, lo_q, lo_d;

    logic [XLEN-1:0]    b_op, target, alu_res;
    logic [REGADDR-1:0] dest;
    logic [SHW-1:0]     shamt;
    logic [XLEN:0]      mul_sum;
    logic               can_load, accept, is_mul, is_div, busy, finish, complete;

    assign b_op     = alu_src ? imm : rt_data;
    assign dest     = reg_dst ? rd_addr : rt_addr;
    assign target   = npc + (imm << 2);
    assign shamt    = rs_data[SHW-1:0];
    assign can_load = !out_valid_q || out_ready;
    assign in_ready = (state_q == S_IDLE) && can_load;
    assign accept   = in_valid && in_ready && !flush;
    assign is_mul   = (alu_ctrl == 4'd11);
    assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
    assign finish   = busy && (cnt_q == '0);
    assign complete = !flush && can_load && (finish || state_q == S_DONE);

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            4'd0:    alu_res = rs_data + b_op;
            4'd1:    alu_res = rs_data - b_op;
            4'd2:    alu_res = rs_data & b_op;
            4'd3:    alu_res = rs_data | b_op;
            4'd4:    alu_res = rs_data ^ b_op;
            4'd5:    alu_res = ~(rs_data | b_op);
            4'd6:    alu_res = XLEN'($signed(rs_data) < $signed(b_op));
            4'd7:    alu_res = XLEN'(rs_data < b_op);
            4'd8:    alu_res = b_op << shamt;
            4'd9:    alu_res = b_op >> shamt;
            4'd10:   alu_res = $unsigned($signed(b_op) >>> shamt);
            4'd13:   alu_res = hi_q;
            4'd14:   alu_res = lo_q;
            4'd15:   alu_res = b_op << (XLEN / 2);
            default: alu_res = '0;
        endcase
    end

    // Shift-add: {carry, hi} accumulates the multiplicand while the multiplier shifts out of lo.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);

`ifdef EXEC_DIV_EN
    logic [XLEN:0]   div_rem;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    assign is_div   = (alu_ctrl == 4'd12);
    assign div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge   = (div_rem >= {1'b0, opb_q});
    assign div_diff = div_rem[XLEN-1:0] - opb_q;

    always_comb begin
        acc_step = {mul_sum, acc_q[XLEN-1:1]};
        if (state_q == S_DIV)
            acc_step = {div_ge ? div_diff : div_rem[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
    end
`else
    assign is_div   = 1'b0;
    assign acc_step = {mul_sum, acc_q[XLEN-1:1]};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && is_mul)      state_d = S_MUL;
                    else if (accept && is_div) state_d = S_DIV;
                end
                S_MUL, S_DIV: if (cnt_q == '0) state_d = can_load ? S_IDLE : S_DONE;
                S_DONE:       if (can_load)    state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;  acc_d = acc_q;  opb_d = opb_q;
        hold_ctl_d = hold_ctl_q;  hold_target_d = hold_target_q;
        hold_store_d = hold_store_q;  hold_dest_d = hold_dest_q;
        out_valid_d = out_valid_q;  out_ctl_d = out_ctl_q;  out_rw_d = out_rw_q;
        out_zero_d = out_zero_q;  out_target_d = out_target_q;  out_alu_d = out_alu_q;
        out_store_d = out_store_q;  out_dest_d = out_dest_q;
        hi_d = hi_q;  lo_d = lo_q;

        if (busy) begin
            acc_d = acc_step;
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end

        if (flush) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else if (complete) begin
            // HI/LO commit together with the entry; a stalled result waits in acc_q.
            out_valid_d  = 1'b1;
            out_ctl_d    = hold_ctl_q;
            out_rw_d     = 1'b0;
            out_zero_d   = 1'b1;
            out_alu_d    = '0;
            out_target_d = hold_target_q;
            out_store_d  = hold_store_q;
            out_dest_d   = hold_dest_q;
            {hi_d, lo_d} = (state_q == S_DONE) ? acc_q : acc_step;
        end else if (accept) begin
            if (is_mul || is_div) begin
                acc_d         = {{XLEN{1'b0}}, rs_data};
                opb_d         = b_op;
                cnt_d         = CNT_LAST;
                hold_ctl_d    = {branch, mem_read, mem_write, mem_to_reg};
                hold_target_d = target;
                hold_store_d  = rt_data;
                hold_dest_d   = dest;
                out_valid_d   = 1'b0;
            end else begin
                out_valid_d  = 1'b1;
                out_ctl_d    = {branch, mem_read, mem_write, mem_to_reg};
                out_rw_d     = reg_write && (alu_ctrl != 4'd12);
                out_zero_d   = (alu_res == '0);
                out_alu_d    = alu_res;
                out_target_d = target;
                out_store_d  = rt_data;
                out_dest_d   = dest;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;  acc_q <= '0;  opb_q <= '0;
            hold_ctl_q <= '0;  hold_target_q <= '0;  hold_store_q <= '0;  hold_dest_q <= '0;
            out_valid_q <= 1'b0;  out_ctl_q <= '0;  out_rw_q <= 1'b0;  out_zero_q <= 1'b0;
            out_target_q <= '0;  out_alu_q <= '0;  out_store_q <= '0;  out_dest_q <= '0;
            hi_q <= '0;  lo_q <= '0;
        end else begin
            cnt_q <= cnt_d;  acc_q <= acc_d;  opb_q <= opb_d;
            hold_ctl_q <= hold_ctl_d;  hold_target_q <= hold_target_d;
            hold_store_q <= hold_store_d;  hold_dest_q <= hold_dest_d;
            out_valid_q <= out_valid_d;  out_ctl_q <= out_ctl_d;  out_rw_q <= out_rw_d;
            out_zero_q <= out_zero_d;  out_target_q <= out_target_d;  out_alu_q <= out_alu_d;
            out_store_q <= out_store_d;  out_dest_q <= out_dest_d;
            hi_q <= hi_d;  lo_q <= lo_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign {out_branch, out_mem_read, out_mem_write, out_mem_to_reg} = out_ctl_q;
    assign out_reg_write  = out_rw_q;
    assign out_zero       = out_zero_q;
    assign out_target     = out_target_q;
    assign out_alu        = out_alu_q;
    assign out_store      = out_store_q;
    assign out_dest       = out_dest_q;
    assign hi             = hi_q;
    assign lo             = lo_q;
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Parametrised MIPS-style execute stage with an integrated EX/MEM pipeline register and a valid/ready handshake on both sides.
- Adds an iterative multi-cycle multiplier (and optional divider) writing HI/LO, upstream stall while busy, and flush.
- Sits between the ID/EX register and the memory stage. Resolves branch taken/target in EX.

Parameters:
XLEN, 32, datapath width (even, >=8)
REGADDR, 5, register-address width
SHW, 5, shift-amount width (= log2 XLEN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
flush  in  1  kill outgoing entry and any in-flight multi-cycle op
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept
alu_src  in  1  0: B=rt_data, 1: B=imm
reg_dst  in  1  0: dest=rt_addr, 1: dest=rd_addr
branch, mem_read, mem_write, reg_write, mem_to_reg  in  1 each  control
alu_ctrl  in  4  operation code
npc  in  XLEN  PC+4
rs_data, rt_data, imm  in  XLEN  A operand, store data, sign-extended immediate
rt_addr, rd_addr  in  REGADDR  destination candidates
out_valid  out  1  EX/MEM entry valid
out_ready  in  1  downstream accepts
out_branch, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  out  1 each  registered control
out_zero  out  1  ALU result == 0
out_target  out  XLEN  npc + (imm<<2)
out_alu  out  XLEN  ALU result
out_store  out  XLEN  rt_data
out_dest  out  REGADDR  destination register
hi, lo  out  XLEN  architectural HI/LO

Behaviour:
- Reset (async): all out_* = 0, out_valid = 0, hi = lo = 0, FSM = IDLE, counter = 0.
- alu_ctrl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL, 9 SRL, 10 SRA (shift B by A[SHW-1:0]), 11 MULTU, 12 DIVU, 13 MFHI, 14 MFLO, 15 LUI (B<<XLEN/2). All arithmetic wraps mod 2^XLEN.
- in_ready = (FSM==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Single-cycle ops: on accept, the EX/MEM register loads next edge (latency 1). out_branch=branch. Taken = out_branch & out_zero (downstream).
- Output hold: out_valid && !out_ready -> all out_* stable. If downstream drains with no accept, out_valid -> 0.
- FSM states:
  - IDLE -> MUL on accepted MULTU.
  - IDLE -> DIV on accepted DIVU.
  - MUL/DIV -> IDLE after exactly XLEN busy cycles (counter XLEN-1 down to 0), then HI/LO update.
  - Accepted entry is captured in an internal holding register. Stage output receives a bubble (out_valid=0) until completion.
  - On completion, if !out_valid || out_ready: load the entry with out_reg_write forced 0 and out_alu=0. Otherwise wait in DONE, then load.
- MULTU: shift-add, 1 bit/cycle. {hi,lo} = rs_data*B (2*XLEN bits, unsigned).
- DIVU: restoring divider, 1 bit/cycle. lo = quotient, hi = remainder. Divisor 0 -> lo = all ones, hi = rs_data.
- MFHI/MFLO read the current hi/lo. No hazard is possible, since in_ready=0 while busy.
- Flush (priority over accept and completion): next edge out_valid=0, FSM -> IDLE, hi/lo unchanged, the same-cycle input is not accepted.
- Reset mid-op: abort, no HI/LO update.

Optional Feature:
EXEC_DIV_EN:
- Defined: DIV state and restoring divider present, alu_ctrl 12 behaves as above.
- Undefined: no divider logic. alu_ctrl 12 completes in 1 cycle with out_alu=0, out_reg_write forced 0, hi/lo unchanged.

Test Plan:
- ADD rs=7, imm=-3, alu_src=1, accept cycle 0 -> cycle 1: out_valid=1, out_alu=4, out_zero=0.
- SUB rs=rt=0x55, branch=1, npc=0x100, imm=4 -> out_zero=1, out_branch=1, out_target=0x110.
- MULTU rs=0xFFFFFFFF, rt=2, XLEN=32 -> in_ready=0 for 32 cycles. Then hi=1, lo=0xFFFFFFFE, out_reg_write=0. Next MFLO -> out_alu=0xFFFFFFFE.
- DIVU 100/7 (EXEC_DIV_EN) -> lo=14, hi=2. Divisor 0, rs=9 -> lo=0xFFFFFFFF, hi=9. Without macro: hi/lo unchanged, out_alu=0.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0. Release -> pending input accepted next edge.
- flush asserted at MULTU cycle 10, or RST pulsed mid-op -> FSM IDLE, out_valid=0, hi/lo keep previous values, in_ready=1 next cycle.
